// File: rtl/fanout_group_sequencer.sv
// fanout_group_sequencer: captures one source value and hands it to up to
// NUM_GROUPS sink banks in turn, lowest index first. An optional idle gap
// follows each transfer except the last one.
module fanout_group_sequencer #(
  parameter int WIDTH      = 1,
  parameter int NUM_GROUPS = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [NUM_GROUPS-1:0] grp_mask,
  input  logic [NUM_GROUPS-1:0] grp_rdy,
  output logic [NUM_GROUPS-1:0] grp_en,
  output logic [WIDTH-1:0]      bcast_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           bcast_cnt
);

  localparam int PTR_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  // The gap counter runs from GAP_CYCLES-1 down to 0, giving GAP_CYCLES idle cycles.
  localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  state_t                state, state_nxt;
  logic [NUM_GROUPS-1:0] mask_q;
  logic [NUM_GROUPS-1:0] mask_rem;
  logic [PTR_W-1:0]      ptr;
  logic [7:0]            gap_cnt;
  logic                  accept;
  logic                  xfer;

  // Priority encode: index of the lowest set bit (0 when the mask is empty).
  function automatic logic [PTR_W-1:0] lowest(input logic [NUM_GROUPS-1:0] m);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = NUM_GROUPS - 1; i >= 0; i--)
      if (m[i]) idx = PTR_W'(i);
    return idx;
  endfunction

  assign accept   = in_valid && (state == IDLE);
  assign xfer     = (state == ISSUE) && grp_rdy[ptr];
  assign mask_rem = mask_q & ~(NUM_GROUPS'(1) << ptr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision; no gap after the final group
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = (grp_mask == '0) ? DONE : ISSUE;
      ISSUE: if (grp_rdy[ptr]) begin
               if (mask_rem == '0)     state_nxt = DONE;
               else if (GAP_CYCLES > 0) state_nxt = GAP;
               else                    state_nxt = ISSUE;
             end
      GAP:   if (gap_cnt == 8'd0) state_nxt = (mask_q == '0) ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    done     = (state == DONE);
    grp_en   = (state == ISSUE) ? (NUM_GROUPS'(1) << ptr) : '0;
  end

  // Datapath: captured value, remaining mask, group pointer, gap timer, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcast_data <= '0;
      mask_q     <= '0;
      ptr        <= '0;
      gap_cnt    <= '0;
      bcast_cnt  <= '0;
    end else begin
      if (accept) begin
        bcast_data <= in_data;
        mask_q     <= grp_mask;
        ptr        <= lowest(grp_mask);
      end
      if (xfer) begin
        mask_q  <= mask_rem;
        ptr     <= lowest(mask_rem);
        gap_cnt <= GAP_LOAD;
      end
      if ((state == GAP) && (gap_cnt != 8'd0)) gap_cnt <= gap_cnt - 8'd1;
      if (state == DONE) bcast_cnt <= bcast_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fanout_group_sequencer.sv
// Bench for fanout_group_sequencer: two instances (gap 0 and gap 2) share
// stimulus; each broadcast's timeline is predicted from the group order,
// the ready pattern and the gap length.
module tb_fanout_group_sequencer;
  localparam int NG   = 4;
  localparam int W    = 8;
  localparam int MAXC = 96;

  logic          clk, rst_n, in_valid;
  logic [W-1:0]  in_data;
  logic [NG-1:0] grp_mask, grp_rdy;
  logic          rdy_o [2];
  logic [NG-1:0] en_o  [2];
  logic [W-1:0]  dat_o [2];
  logic          busy_o[2];
  logic          done_o[2];
  logic [15:0]   cnt_o [2];

  int            checks = 0;
  int            errors = 0;
  logic [15:0]   model_cnt;
  logic [NG-1:0] rdy_tab [MAXC];
  int            exp_en  [2][MAXC];
  int            exp_done[2];

  fanout_group_sequencer #(.WIDTH(W), .NUM_GROUPS(NG), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[0]),
    .in_data(in_data), .grp_mask(grp_mask), .grp_rdy(grp_rdy), .grp_en(en_o[0]),
    .bcast_data(dat_o[0]), .busy(busy_o[0]), .done(done_o[0]), .bcast_cnt(cnt_o[0]));

  fanout_group_sequencer #(.WIDTH(W), .NUM_GROUPS(NG), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[1]),
    .in_data(in_data), .grp_mask(grp_mask), .grp_rdy(grp_rdy), .grp_en(en_o[1]),
    .bcast_data(dat_o[1]), .busy(busy_o[1]), .done(done_o[1]), .bcast_cnt(cnt_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_rdy_d%0d", tag, d),  32'(rdy_o[d]),  32'd1);
      chk($sformatf("%s_en_d%0d", tag, d),   32'(en_o[d]),   32'd0);
      chk($sformatf("%s_data_d%0d", tag, d), 32'(dat_o[d]),  32'd0);
      chk($sformatf("%s_busy_d%0d", tag, d), 32'(busy_o[d]), 32'd0);
      chk($sformatf("%s_done_d%0d", tag, d), 32'(done_o[d]), 32'd0);
      chk($sformatf("%s_cnt_d%0d", tag, d),  32'(cnt_o[d]),  32'd0);
    end
  endtask

  task automatic fill_rdy(input int mode);
    for (int c = 0; c < MAXC; c++)
      rdy_tab[c] = (mode == 1 && c < 48) ? NG'($urandom_range(15) | $urandom_range(15)) : '1;
  endtask

  // Expected schedule: walk the set groups in ascending order; each is
  // enabled from its start cycle until the first cycle its ready is high,
  // then the next starts 1+G cycles later. done follows the last transfer.
  task automatic predict(input logic [NG-1:0] mask);
    for (int d = 0; d < 2; d++) begin
      int g_len, cur, last;
      g_len = 2 * d;
      cur = 1;
      last = 0;
      for (int c = 0; c < MAXC; c++) exp_en[d][c] = -1;
      for (int g = 0; g < NG; g++) begin
        if (mask[g]) begin
          while (!rdy_tab[cur][g]) begin
            exp_en[d][cur] = g;
            cur++;
          end
          exp_en[d][cur] = g;
          last = cur;
          cur += 1 + g_len;
        end
      end
      exp_done[d] = (mask == '0) ? 1 : last + 1;
    end
  endtask

  // Called at a negedge with the bench idle: offers one value, then checks
  // every cycle until both instances are back in IDLE.
  task automatic run_bcast(input string tag, input logic [NG-1:0] mask, input logic [W-1:0] data);
    int stop;
    logic [15:0] nxt;
    predict(mask);
    nxt = model_cnt + 16'd1;
    stop = ((exp_done[0] > exp_done[1]) ? exp_done[0] : exp_done[1]) + 1;
    in_valid = 1'b1;
    in_data  = data;
    grp_mask = mask;
    for (int c = 1; c <= stop; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      grp_mask = NG'($urandom);
      grp_rdy  = rdy_tab[c];
      #1;
      for (int d = 0; d < 2; d++) begin
        logic [NG-1:0] e;
        int dc;
        dc = exp_done[d];
        e = (c < dc && exp_en[d][c] >= 0) ? (NG'(1) << exp_en[d][c]) : '0;
        chk($sformatf("%s_c%0d_d%0d_en", tag, c, d),   32'(en_o[d]),   32'(e));
        chk($sformatf("%s_c%0d_d%0d_busy", tag, c, d), 32'(busy_o[d]), 32'(c <= dc));
        chk($sformatf("%s_c%0d_d%0d_done", tag, c, d), 32'(done_o[d]), 32'(c == dc));
        chk($sformatf("%s_c%0d_d%0d_rdy", tag, c, d),  32'(rdy_o[d]),  32'(c > dc));
        chk($sformatf("%s_c%0d_d%0d_data", tag, c, d), 32'(dat_o[d]),  32'(data));
        chk($sformatf("%s_c%0d_d%0d_cnt", tag, c, d),  32'(cnt_o[d]),  32'((c > dc) ? nxt : model_cnt));
      end
    end
    model_cnt = nxt;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; grp_mask = '0; grp_rdy = '0;
    model_cnt = '0;
    repeat (2) @(negedge clk);
    #1 check_reset("por");
    rst_n = 1'b1;

    fill_rdy(0); run_bcast("all4",  4'b1111, 8'h01);
    fill_rdy(0); run_bcast("m1010", 4'b1010, 8'hA5);
    fill_rdy(0);
    for (int c = 3; c <= 5; c++) rdy_tab[c][2] = 1'b0;
    run_bcast("bp2", 4'b1111, 8'h3C);
    fill_rdy(0); run_bcast("zero",  4'b0000, 8'h5A);
    for (int i = 0; i < 40; i++) begin
      fill_rdy(1);
      run_bcast($sformatf("rnd%0d", i), NG'($urandom), W'($urandom));
    end

    // Asynchronous reset in the middle of a broadcast
    fill_rdy(0);
    in_valid = 1'b1; in_data = 8'hC3; grp_mask = 4'b1111;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    model_cnt = '0;
    @(negedge clk);
    check_reset("heldrst");
    rst_n = 1'b1;
    fill_rdy(0); run_bcast("postrst", 4'b0110, 8'h77);

    // Counter wrap from 0xFFFF
    @(negedge clk);
    force dut0.bcast_cnt = 16'hFFFF;
    force dut2.bcast_cnt = 16'hFFFF;
    #1;
    release dut0.bcast_cnt;
    release dut2.bcast_cnt;
    model_cnt = 16'hFFFF;
    fill_rdy(0); run_bcast("wrap",  4'b0000, 8'h11);
    fill_rdy(0); run_bcast("after", 4'b1001, 8'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
